// File: rtl/mux2_arbiter_pkg.sv
// Shared types and defaults for the two-requester round-robin mux arbiter.
// The optional grant timeout is enabled by defining ARB_TIMEOUT_EN (off by default).
package mux2_arbiter_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned MAX_HOLD_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_e;

  // Hold counter must be able to represent MAX_HOLD itself.
  function automatic int unsigned hold_cnt_width(input int unsigned max_hold);
    return (max_hold < 2) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/mux2_arbiter_if.sv
// Request/data/grant bundle between two producers, the arbiter and the sink.
interface mux2_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic                  req0;
  logic                  req1;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] din1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  sel;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dvalid;

  // Producer/sink side drives requests and data, observes grants and output.
  modport master (
    output req0, req1, din0, din1,
    input  gnt0, gnt1, sel, dout, dvalid
  );

  // Arbiter side.
  modport slave (
    input  req0, req1, din0, din1,
    output gnt0, gnt1, sel, dout, dvalid
  );

endinterface

// File: rtl/mux2_arbiter_hold_counter.sv
// Counts contended grant cycles; only instantiated when ARB_TIMEOUT_EN is defined.
module mux2_arbiter_hold_counter
  import mux2_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CW = hold_cnt_width(MAX_HOLD);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal when the next enabled cycle brings the count up to MAX_HOLD.
  assign tc_o = en_i && (cnt_q == CW'(MAX_HOLD - 1));

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter for two requesters sharing one registered 2:1 data mux,
// with a one-cycle break-before-make gap; ARB_TIMEOUT_EN adds a MAX_HOLD grant limit.
module mux2_arbiter
  import mux2_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned MAX_HOLD   = MAX_HOLD_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  mux2_arbiter_if.slave  bus
);

  arb_state_e            state_q;
  arb_state_e            state_d;
  logic                  last_q;
  logic                  last_d;
  logic                  gnt0_q;
  logic                  gnt0_d;
  logic                  gnt1_q;
  logic                  gnt1_d;
  logic                  sel_q;
  logic                  sel_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] dout_d;
  logic                  dvalid_q;
  logic                  dvalid_d;
  logic [DATA_WIDTH-1:0] mux_c;
  logic                  contend_c;
  logic                  timeout_c;

  assign mux_c     = sel_q ? bus.din1 : bus.din0;
  assign contend_c = ((state_q == GNT0) && bus.req1) || ((state_q == GNT1) && bus.req0);

`ifdef ARB_TIMEOUT_EN
  mux2_arbiter_hold_counter #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (state_q == IDLE),
    .en_i    (contend_c),
    .tc_o    (timeout_c)
  );
`else
  logic unused_cfg;
  assign timeout_c  = 1'b0;
  assign unused_cfg = ^{32'(MAX_HOLD), contend_c};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      sel_q    <= 1'b0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      sel_q    <= sel_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  // Grants are locked until release or timeout; every release passes through IDLE.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 && (!bus.req1 || last_q)) begin
          state_d = GNT0;
        end else if (bus.req1) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!bus.req0 || timeout_c) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      GNT1: begin
        if (!bus.req1 || timeout_c) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Select only moves when leaving IDLE, so it never changes under a live grant.
  always_comb begin
    gnt0_d   = (state_d == GNT0);
    gnt1_d   = (state_d == GNT1);
    sel_d    = sel_q;
    dout_d   = dout_q;
    dvalid_d = (state_q != IDLE);
    if ((state_q == IDLE) && (state_d == GNT0)) begin
      sel_d = 1'b0;
    end else if ((state_q == IDLE) && (state_d == GNT1)) begin
      sel_d = 1'b1;
    end
    if (state_q != IDLE) begin
      dout_d = mux_c;
    end
  end

  assign bus.gnt0   = gnt0_q;
  assign bus.gnt1   = gnt1_q;
  assign bus.sel    = sel_q;
  assign bus.dout   = dout_q;
  assign bus.dvalid = dvalid_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed scoreboard bench for mux2_arbiter; expectations follow ARB_TIMEOUT_EN if defined.
module tb_mux2_arbiter;

  localparam int unsigned DW       = 8;
  localparam int unsigned MAX_HOLD = 3;

  typedef logic [DW+3:0] obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mux2_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  mux2_arbiter #(
    .DATA_WIDTH (DW),
    .MAX_HOLD   (MAX_HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic obs_t pack(input logic g0, input logic g1, input logic s,
                                input logic dv, input logic [DW-1:0] d);
    return {g0, g1, s, dv, d};
  endfunction

  task automatic expect_out(input logic g0, input logic g1, input logic s,
                            input logic dv, input logic [DW-1:0] d);
    exp_q.push_back(pack(g0, g1, s, dv, d));
  endtask

  task automatic check(input string tag);
    obs_t e;
    obs_t o;
    e = exp_q.pop_front();
    o = {bus.gnt0, bus.gnt1, bus.sel, bus.dvalid, bus.dout};
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed g0=%b g1=%b sel=%b dv=%b dout=%h, expected g0=%b g1=%b sel=%b dv=%b dout=%h",
             tag, o[DW+3], o[DW+2], o[DW+1], o[DW], o[DW-1:0],
             e[DW+3], e[DW+2], e[DW+1], e[DW], e[DW-1:0]);
    end
    tests++;
    assert (!(bus.gnt0 && bus.gnt1)) else begin
      fails++;
      $error("FAIL %s_mutex: observed gnt0=%b gnt1=%b, expected not both high", tag, bus.gnt0, bus.gnt1);
    end
  endtask

  // Drive inputs, queue the hand-derived post-edge outputs, then compare after the edge.
  task automatic step(input string tag, input logic r0, input logic r1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic g0, input logic g1, input logic s,
                      input logic dv, input logic [DW-1:0] d);
    bus.req0 = r0;
    bus.req1 = r1;
    bus.din0 = d0;
    bus.din1 = d1;
    expect_out(g0, g1, s, dv, d);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.din0 = '0;
    bus.din1 = '0;
    #12;
    expect_out(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("reset_init");
    rst_n = 1'b1;

    // Single requester, four cycles.
    step("single_g1",   1, 0, 8'h3C, 8'h00, 1, 0, 0, 0, 8'h00);
    step("single_g2",   1, 0, 8'h3C, 8'h00, 1, 0, 0, 1, 8'h3C);
    step("single_g3",   1, 0, 8'h3C, 8'h00, 1, 0, 0, 1, 8'h3C);
    step("single_g4",   1, 0, 8'h3C, 8'h00, 1, 0, 0, 1, 8'h3C);
    step("single_rel",  0, 0, 8'h3C, 8'h00, 0, 0, 0, 1, 8'h3C);
    step("single_idle", 0, 0, 8'h3C, 8'h00, 0, 0, 0, 0, 8'h3C);

    // Asynchronous reset in the middle of a GNT1 carrying 8'hA5.
    step("mid_g1",      0, 1, 8'h3C, 8'hA5, 0, 1, 1, 0, 8'h3C);
    step("mid_g2",      0, 1, 8'h3C, 8'hA5, 0, 1, 1, 1, 8'hA5);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("reset_async");
    bus.req1 = 1'b0;
    @(posedge clk);
    #1;
    expect_out(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("reset_held");
    rst_n = 1'b1;

    // Tie straight after reset: req0 wins, then a gap, then req1.
    step("tie_g0",      1, 1, 8'h11, 8'h22, 1, 0, 0, 0, 8'h00);
    step("tie_rel0",    0, 1, 8'h11, 8'h22, 0, 0, 0, 1, 8'h11);
    step("tie_g1",      0, 1, 8'h11, 8'h22, 0, 1, 1, 0, 8'h11);
    step("tie_g1_dat",  0, 1, 8'h11, 8'h22, 0, 1, 1, 1, 8'h22);
    step("tie_rel1",    0, 0, 8'h11, 8'h22, 0, 0, 1, 1, 8'h22);
    step("tie_idle",    0, 0, 8'h11, 8'h22, 0, 0, 1, 0, 8'h22);

    // Fairness: each side drops after two granted cycles.
    step("fair_a0",     1, 1, 8'hA1, 8'hB2, 1, 0, 0, 0, 8'h22);
    step("fair_a1",     1, 1, 8'hA1, 8'hB2, 1, 0, 0, 1, 8'hA1);
    step("fair_gap1",   0, 1, 8'hA1, 8'hB2, 0, 0, 0, 1, 8'hA1);
    step("fair_b0",     1, 1, 8'hA1, 8'hB2, 0, 1, 1, 0, 8'hA1);
    step("fair_b1",     1, 1, 8'hA1, 8'hB2, 0, 1, 1, 1, 8'hB2);
    step("fair_gap2",   1, 0, 8'hA1, 8'hB2, 0, 0, 1, 1, 8'hB2);
    step("fair_c0",     1, 1, 8'hA1, 8'hB2, 1, 0, 0, 0, 8'hB2);
    step("fair_c1",     1, 1, 8'hA1, 8'hB2, 1, 0, 0, 1, 8'hA1);
    step("fair_gap3",   0, 1, 8'hA1, 8'hB2, 0, 0, 0, 1, 8'hA1);
    step("fair_d0",     0, 1, 8'hA1, 8'hB2, 0, 1, 1, 0, 8'hA1);
    step("fair_rel",    0, 0, 8'hA1, 8'hB2, 0, 0, 1, 1, 8'hB2);
    step("fair_idle",   0, 0, 8'hA1, 8'hB2, 0, 0, 1, 0, 8'hB2);

    // req0 stuck high, req1 raised: timeout handover or permanent lock.
    step("hold_g0",     1, 0, 8'hC3, 8'h5A, 1, 0, 0, 0, 8'hB2);
`ifdef ARB_TIMEOUT_EN
    step("tmo_c1",      1, 1, 8'hC3, 8'h5A, 1, 0, 0, 1, 8'hC3);
    step("tmo_c2",      1, 1, 8'hC3, 8'h5A, 1, 0, 0, 1, 8'hC3);
    step("tmo_c3_rel",  1, 1, 8'hC3, 8'h5A, 0, 0, 0, 1, 8'hC3);
    step("tmo_g1",      1, 1, 8'hC3, 8'h5A, 0, 1, 1, 0, 8'hC3);
    step("tmo_g1_dat",  1, 1, 8'hC3, 8'h5A, 0, 1, 1, 1, 8'h5A);
    step("tmo_rel1",    0, 0, 8'hC3, 8'h5A, 0, 0, 1, 1, 8'h5A);
    step("tmo_idle",    0, 0, 8'hC3, 8'h5A, 0, 0, 1, 0, 8'h5A);
`else
    step("lock_c1",     1, 1, 8'hC3, 8'h5A, 1, 0, 0, 1, 8'hC3);
    for (int i = 0; i < 20; i++) begin
      step($sformatf("lock_hold%0d", i), 1, 1, 8'hC3, 8'h5A, 1, 0, 0, 1, 8'hC3);
    end
    step("lock_rel0",   0, 1, 8'hC3, 8'h5A, 0, 0, 0, 1, 8'hC3);
    step("lock_g1",     0, 1, 8'hC3, 8'h5A, 0, 1, 1, 0, 8'hC3);
    step("lock_rel1",   0, 0, 8'hC3, 8'h5A, 0, 0, 1, 1, 8'h5A);
    step("lock_idle",   0, 0, 8'hC3, 8'h5A, 0, 0, 1, 0, 8'h5A);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
